// File: rtl/jedro_1_operand_fetch.sv
// Operand fetch stage for a single-port register file.
// A request latches rs1/rs2 addresses, reads rs1 then (optionally) rs2 through
// the shared port, and presents both operands until the consumer accepts them.
// Writebacks share the same port and are only accepted when the port is idle
// (IDLE or VALID); while VALID, a matching writeback is forwarded into the
// held operands so the consumer never sees a stale value.
//
// Handshake rule for all three interfaces: a transfer happens on a rising
// clk_i edge where valid and ready are both high; valid and its payload are
// held by the sender until that edge, and ready never depends on the
// sender's payload.
module jedro_1_operand_fetch #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic                  use_rs2_i,
  output logic                  op_valid_o,
  input  logic                  op_ready_i,
  output logic [DATA_WIDTH-1:0] rs1_data_o,
  output logic [DATA_WIDTH-1:0] rs2_data_o,
  input  logic                  wb_valid_i,
  output logic                  wb_ready_o,
  input  logic [ADDR_WIDTH-1:0] wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic [ADDR_WIDTH-1:0] rf_addr_o,
  output logic [DATA_WIDTH-1:0] rf_data_o,
  output logic                  rf_we_o,
  input  logic [DATA_WIDTH-1:0] rf_data_i,
  output logic [2:0]            state_dbg_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD1   = 3'd1,
    RD2   = 3'd2,
    CAP2  = 3'd3,
    VALID = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rs1_addr_q, rs1_addr_d;
  logic [ADDR_WIDTH-1:0]   rs2_addr_q, rs2_addr_d;
  logic                    use_rs2_q, use_rs2_d;
  logic [DATA_WIDTH-1:0]   rs1_data_q, rs1_data_d;
  logic [DATA_WIDTH-1:0]   rs2_data_q, rs2_data_d;
  logic                    req_hs;
  logic                    wb_hs;
  logic                    wb_nonzero;

  // Handshake qualifiers; writeback has priority over a request in IDLE.
  assign req_ready_o = (state_q == IDLE) & ~wb_valid_i;
  assign wb_ready_o  = (state_q == IDLE) | (state_q == VALID);
  assign req_hs      = req_valid_i & req_ready_o;
  assign wb_hs       = wb_valid_i & wb_ready_o;
  assign wb_nonzero  = (wb_addr_i != '0);

  assign op_valid_o  = (state_q == VALID);
  assign rs1_data_o  = rs1_data_q;
  assign rs2_data_o  = rs2_data_q;
  assign state_dbg_o = state_q;

  // Next-state logic: fixed read sequence, rs2 read skipped when not needed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_hs) state_d = RD1;
      RD1:     state_d = RD2;
      RD2:     state_d = use_rs2_q ? CAP2 : VALID;
      CAP2:    state_d = VALID;
      VALID:   if (op_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Register-file port mux: writeback owns the port whenever it is accepted;
  // otherwise the read sequence drives the address and writes stay off.
  always_comb begin
    rf_addr_o = '0;
    rf_data_o = '0;
    rf_we_o   = 1'b0;
    if (wb_hs) begin
      rf_addr_o = wb_addr_i;
      rf_data_o = wb_data_i;
      rf_we_o   = wb_nonzero;
    end else begin
      case (state_q)
        RD1:     rf_addr_o = rs1_addr_q;
        RD2:     rf_addr_o = use_rs2_q ? rs2_addr_q : '0;
        default: rf_addr_o = '0;
      endcase
    end
  end

  // Datapath: latch addresses on accept, capture read data (x0 reads as 0),
  // and forward matching writebacks into the held operands while VALID.
  always_comb begin
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    use_rs2_d  = use_rs2_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    case (state_q)
      IDLE: begin
        if (req_hs) begin
          rs1_addr_d = rs1_addr_i;
          rs2_addr_d = rs2_addr_i;
          use_rs2_d  = use_rs2_i;
        end
      end
      RD2: begin
        rs1_data_d = (rs1_addr_q == '0) ? '0 : rf_data_i;
        if (!use_rs2_q) rs2_data_d = '0;
      end
      CAP2: begin
        rs2_data_d = (rs2_addr_q == '0) ? '0 : rf_data_i;
      end
      VALID: begin
        if (wb_hs && wb_nonzero) begin
          if (wb_addr_i == rs1_addr_q) rs1_data_d = wb_data_i;
          if (use_rs2_q && (wb_addr_i == rs2_addr_q)) rs2_data_d = wb_data_i;
        end
      end
      default: ;
    endcase
  end

  // State and datapath registers with asynchronous active-low clear.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      use_rs2_q  <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      use_rs2_q  <= use_rs2_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
    end
  end

endmodule

// File: tb/tb_jedro_1_operand_fetch.sv
// Testbench for jedro_1_operand_fetch: external register file, driver tasks,
// a reference model of architectural register state, and a queue-based
// scoreboard checked at every falling edge.
module tb_jedro_1_operand_fetch;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn_i;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          req_valid_i, req_ready_o, use_rs2_i;
  logic [AW-1:0] rs1_addr_i, rs2_addr_i;
  logic          op_valid_o, op_ready_i;
  logic [DW-1:0] rs1_data_o, rs2_data_o;
  logic          wb_valid_i, wb_ready_o;
  logic [AW-1:0] wb_addr_i;
  logic [DW-1:0] wb_data_i;
  logic [AW-1:0] rf_addr_o;
  logic [DW-1:0] rf_data_o, rf_data_i;
  logic          rf_we_o;
  logic [2:0]    state_dbg_o;

  jedro_1_operand_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .use_rs2_i(use_rs2_i),
    .op_valid_o(op_valid_o), .op_ready_i(op_ready_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .rf_addr_o(rf_addr_o), .rf_data_o(rf_data_o), .rf_we_o(rf_we_o),
    .rf_data_i(rf_data_i), .state_dbg_o(state_dbg_o)
  );

  // ---------------- external register file ----------------
  logic [DW-1:0] init_val [NR];
  logic [DW-1:0] rf_mem [NR];
  logic [DW-1:0] rf_q = '0;
  logic          mem_loaded = 1'b0;
  logic          rf_force = 1'b0;
  assign rf_data_i = rf_force ? '1 : rf_q;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < NR; i++) rf_mem[i] <= init_val[i];
      mem_loaded <= 1'b1;
    end else if (rf_we_o) begin
      rf_mem[rf_addr_o] <= rf_data_o;
    end
    rf_q <= rf_mem[rf_addr_o];
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          use2;
    logic          frc;
    int            acc;
  } req_t;

  req_t          exp_q[$];
  logic [DW-1:0] ref_regs [NR];
  int            n_checks = 0;
  int            n_fail = 0;

  function automatic logic [DW-1:0] ref_val(input logic [AW-1:0] a, input logic frc);
    if (a == '0) return '0;
    if (frc) return '1;
    return ref_regs[a];
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, expv, cyc);
    end
  endtask

  // Monitor: phase of the model is derived purely from acceptance time and
  // the operand count (2 or 3 cycles to VALID).
  int            ph;
  int            lat;
  int            off;
  logic          wb_rdy_e, wb_hs_e, req_hs_e;
  logic [DW-1:0] e1, e2;
  req_t          nr;

  always @(negedge clk) begin
    if (!rstn_i) begin
      exp_q.delete();
    end else begin
      ph = 0;
      off = 0;
      if (exp_q.size() != 0) begin
        lat = exp_q[0].use2 ? 3 : 2;
        off = cyc - exp_q[0].acc;
        ph = (cyc < exp_q[0].acc + lat) ? 1 : 2;
      end
      wb_rdy_e = (ph != 1);
      wb_hs_e  = wb_valid_i & wb_rdy_e;
      req_hs_e = req_valid_i & (ph == 0) & ~wb_valid_i;

      check("req_ready", {63'd0, req_ready_o}, {63'd0, (ph == 0) && !wb_valid_i});
      check("wb_ready", {63'd0, wb_ready_o}, {63'd0, wb_rdy_e});
      check("op_valid", {63'd0, op_valid_o}, {63'd0, ph == 2});
      check("rf_we", {63'd0, rf_we_o}, {63'd0, wb_hs_e && (wb_addr_i != '0)});
      if (wb_hs_e) begin
        check("rf_addr_wb", 64'(rf_addr_o), 64'(wb_addr_i));
        check("rf_data_wb", 64'(rf_data_o), 64'(wb_data_i));
      end else begin
        check("rf_data_idle", 64'(rf_data_o), 64'd0);
        if (ph != 1) check("rf_addr_idle", 64'(rf_addr_o), 64'd0);
      end

      if (ph == 1) begin
        if (off == 0) check("rf_addr_rs1", 64'(rf_addr_o), 64'(exp_q[0].rs1));
        if (off == 1 && exp_q[0].use2) check("rf_addr_rs2", 64'(rf_addr_o), 64'(exp_q[0].rs2));
        if (!exp_q[0].use2 && exp_q[0].rs2 != '0 && exp_q[0].rs2 != exp_q[0].rs1) begin
          n_checks++;
          if (rf_addr_o == exp_q[0].rs2) begin
            n_fail++;
            $display("FAIL rf_addr_no_rs2: got %0h, must differ from unused rs2 at cycle %0d", rf_addr_o, cyc);
          end
        end
      end

      if (ph == 2) begin
        e1 = ref_val(exp_q[0].rs1, exp_q[0].frc);
        e2 = exp_q[0].use2 ? ref_val(exp_q[0].rs2, exp_q[0].frc) : '0;
        check("rs1_data", 64'(rs1_data_o), 64'(e1));
        check("rs2_data", 64'(rs2_data_o), 64'(e2));
        if (op_ready_i) void'(exp_q.pop_front());
      end

      if (wb_hs_e && wb_addr_i != '0) ref_regs[wb_addr_i] = wb_data_i;
      if (req_hs_e) begin
        nr.rs1 = rs1_addr_i;
        nr.rs2 = rs2_addr_i;
        nr.use2 = use_rs2_i;
        nr.frc = rf_force;
        nr.acc = cyc + 1;
        exp_q.push_back(nr);
      end
    end
  end

  // ---------------- consumer ready driver ----------------
  int ready_mode = 1; // 0: hold low, 1: always high, 2: random
  initial begin
    op_ready_i = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      op_ready_i = (ready_mode == 0) ? 1'b0 :
                   (ready_mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_req(input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic u);
    logic ok;
    ok = 1'b0;
    req_valid_i = 1'b1;
    rs1_addr_i = a1;
    rs2_addr_i = a2;
    use_rs2_i = u;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ok = req_ready_o;
      @(posedge clk);
      #2;
      if (ok) break;
    end
    if (!ok) check("req_accept_timeout", 64'd0, 64'd1);
    req_valid_i = 1'b0;
  endtask

  task automatic do_wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic ok;
    ok = 1'b0;
    wb_valid_i = 1'b1;
    wb_addr_i = a;
    wb_data_i = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      ok = wb_ready_o;
      @(posedge clk);
      #2;
      if (ok) break;
    end
    if (!ok) check("wb_accept_timeout", 64'd0, 64'd1);
    wb_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    step(1);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NR - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  // ---------------- main sequence ----------------
  logic rnd_done;
  logic got_valid;

  initial begin
    for (int i = 0; i < NR; i++) begin
      init_val[i] = $urandom;
      ref_regs[i] = init_val[i];
    end
    rstn_i = 1'b0;
    req_valid_i = 1'b0; rs1_addr_i = '0; rs2_addr_i = '0; use_rs2_i = 1'b0;
    wb_valid_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    rnd_done = 1'b0;

    // reset state
    #12;
    check("rst_state", 64'(state_dbg_o), 64'd0);
    check("rst_op_valid", {63'd0, op_valid_o}, 64'd0);
    check("rst_rs1", 64'(rs1_data_o), 64'd0);
    check("rst_rs2", 64'(rs2_data_o), 64'd0);
    step(3);
    rstn_i = 1'b1;
    step(2);

    // two-operand read
    ready_mode = 1;
    do_wb(5'd3, 32'h11);
    do_wb(5'd7, 32'h22);
    do_req(5'd3, 5'd7, 1'b1);
    wait_idle();

    // single-operand read, rs2 address must not appear on the port
    do_req(5'd5, 5'd13, 1'b0);
    wait_idle();

    // x0 reads as zero even when the file returns all ones
    rf_force = 1'b1;
    do_req(5'd0, 5'd4, 1'b1);
    wait_idle();
    rf_force = 1'b0;

    // writeback and request together: write wins, read sees new value
    fork
      do_wb(5'd9, 32'hABCD);
      do_req(5'd9, 5'd0, 1'b0);
    join
    wait_idle();

    // forwarding while VALID is held, then a dropped x0 write
    ready_mode = 0;
    do_req(5'd2, 5'd6, 1'b1);
    got_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (op_valid_o) begin
        got_valid = 1'b1;
        break;
      end
    end
    check("valid_reached", {63'd0, got_valid}, 64'd1);
    step(1);
    do_wb(5'd6, 32'h55);
    check("fwd_rs2", 64'(rs2_data_o), 64'h55);
    do_wb(5'd0, 32'h77);
    ready_mode = 1;
    wait_idle();

    // reset during RD2 discards the request
    ready_mode = 1;
    do_req(5'd1, 5'd2, 1'b1);
    step(1);
    rstn_i = 1'b0;
    #1;
    check("midrst_op_valid", {63'd0, op_valid_o}, 64'd0);
    check("midrst_state", 64'(state_dbg_o), 64'd0);
    step(2);
    rstn_i = 1'b1;
    step(6);
    check("post_rst_state", 64'(state_dbg_o), 64'd0);

    // randomized traffic with concurrent writebacks
    ready_mode = 2;
    fork
      begin
        for (int n = 0; n < 150; n++) begin
          do_req(rand_addr(), rand_addr(), 1'($urandom_range(0, 1)));
          step($urandom_range(0, 3));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          if ($urandom_range(0, 2) == 0) do_wb(rand_addr(), $urandom);
          else step(1);
        end
      end
    join
    ready_mode = 1;
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jedro_1_operand_fetch.md
JEDRO_1_OPERAND_FETCH -- requirements
Module: jedro_1_operand_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register address width.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn_i, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have ports req_valid_i (in, 1) and req_ready_o (out, 1), the operand-request handshake.
REQ-006 SHALL have ports rs1_addr_i and rs2_addr_i (in, ADDR_WIDTH), the source register addresses, and use_rs2_i (in, 1), set when rs2 is needed.
REQ-007 SHALL have ports op_valid_o (out, 1) and op_ready_i (in, 1), the operand-delivery handshake.
REQ-008 SHALL have ports rs1_data_o and rs2_data_o (out, DATA_WIDTH), the delivered operands.
REQ-009 SHALL have ports wb_valid_i (in, 1), wb_ready_o (out, 1), wb_addr_i (in, ADDR_WIDTH) and wb_data_i (in, DATA_WIDTH), the writeback request.
REQ-010 SHALL have ports rf_addr_o (out, ADDR_WIDTH), rf_data_o (out, DATA_WIDTH), rf_we_o (out, 1) and rf_data_i (in, DATA_WIDTH), which drive the single-port register file; rf_data_i is registered and valid one cycle after an address is presented with rf_we_o=0.

Function
REQ-011 SHALL implement states IDLE, RD1, RD2, CAP2 and VALID.
REQ-012 SHALL drive req_ready_o = (state==IDLE) & ~wb_valid_i, and drive wb_ready_o = (state==IDLE) | (state==VALID).
REQ-013 On a request handshake, SHALL latch rs1_addr_i, rs2_addr_i and use_rs2_i, then go IDLE->RD1.
REQ-014 In RD1, SHALL drive rf_addr_o=rs1 and rf_we_o=0, then go RD1->RD2 unconditionally.
REQ-015 In RD2, SHALL capture rs1_data_o from rf_data_i and drive rf_addr_o=rs2.
REQ-016 From RD2, SHALL go to CAP2 if use_rs2, else to VALID with rs2_data_o=0.
REQ-017 In CAP2, SHALL capture rs2_data_o from rf_data_i, then go CAP2->VALID.
REQ-018 Latency SHALL be: op_valid_o high 3 cycles after acceptance with use_rs2=1, and 2 cycles with use_rs2=0.
REQ-019 SHALL assert op_valid_o only in VALID, holding operands stable until op_ready_i=1, then go VALID->IDLE.
REQ-020 SHALL capture an operand whose source address is 0 as 0, regardless of rf_data_i.
REQ-021 On a writeback handshake, SHALL drive rf_addr_o=wb_addr_i and rf_data_o=wb_data_i combinationally, with rf_we_o=1 only if wb_addr_i!=0; an x0 write is acknowledged but dropped.
REQ-022 When not writing, SHALL drive rf_we_o=0 and rf_data_o=0, and drive rf_addr_o=0 in IDLE and VALID.
REQ-023 When wb_valid_i and req_valid_i are both high in IDLE, writeback SHALL win; the request waits at least one cycle.
REQ-024 On a writeback in VALID whose nonzero wb_addr_i equals the latched rs1 (or rs2, when use_rs2), the matching held operand SHALL update to wb_data_i at that edge (forwarding).
REQ-025 In VALID, op_valid_o and its handshake SHALL be unaffected by a simultaneous writeback.
REQ-026 SHALL never assert rf_we_o in RD1, RD2 or CAP2.

Reset
REQ-027 While rstn_i=0, SHALL immediately force state to IDLE, op_valid_o=0, rs1_data_o=0, rs2_data_o=0, and latched addresses to 0.
REQ-028 A reset mid-operation SHALL discard the in-flight request without asserting op_valid_o.
REQ-029 Outputs SHALL follow REQ-012/REQ-022 from the first edge after rstn_i rises.

Verification
REQ-030 Req rs1=3, rs2=7, use_rs2=1 with x3=0x11, x7=0x22 -> op_valid_o 3 cycles later with rs1_data_o=0x11 and rs2_data_o=0x22.
REQ-031 Req rs1=5, use_rs2=0 -> op_valid_o after 2 cycles with rs2_data_o=0, and rf_addr_o never equals rs2.
REQ-032 Req rs1=0, rs2=4 with rf_data_i forced to 0xFFFFFFFF -> rs1_data_o=0.
REQ-033 wb x9=0xABCD and req rs1=9 in the same IDLE cycle -> write first (rf_we_o=1), then the read returns 0xABCD.
REQ-034 In VALID with rs2=6 and op_ready_i=0, wb x6=0x55 -> rs2_data_o becomes 0x55 next cycle; wb x0 -> rf_we_o stays 0.
REQ-035 rstn_i low during RD2 -> op_valid_o=0 and state IDLE immediately, with no operand delivered after release.
